// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO over a single inferred block RAM with a small prefetch stage.
// Define BRAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module bram_fifo #(
  parameter int    WIDTH         = 32,
  parameter int    ADDR_BITS     = 10,
  parameter string TARGET_BRAM   = "36Kb",
  parameter string TARGET_DEVICE = "VIRTEX5",
  parameter int    LATENCY       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [WIDTH-1:0]     din,
  input  logic                 we,
  output logic                 full,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int SLOTS = LATENCY + 1;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);
  localparam logic [1:0] SLOTS_CNT = 2'(SLOTS);

  // An unsupported parameter set leaves the FIFO inert instead of silently misbehaving.
  localparam bit CFG_OK =
    (WIDTH >= 1) && (WIDTH <= 72) && ((WIDTH <= 36) || (TARGET_BRAM == "36Kb")) &&
    (ADDR_BITS >= 9) && ((TARGET_BRAM == "18Kb") || (TARGET_BRAM == "36Kb")) &&
    ((TARGET_DEVICE == "VIRTEX5") || (TARGET_DEVICE == "VIRTEX6") ||
     (TARGET_DEVICE == "SPARTAN6")) && ((LATENCY == 1) || (LATENCY == 2));

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     bram_rd_q;
  logic [WIDTH-1:0]     bram_out_q;

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [ADDR_BITS:0]   bram_cnt_q, bram_cnt_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [1:0]           occ_q, occ_d;
  logic [1:0]           vld_q, vld_d;
  logic [WIDTH-1:0]     skid_q [SLOTS];
  logic [WIDTH-1:0]     skid_d [SLOTS];
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  logic                 wr_acc;
  logic                 pop;
  logic                 issue;
  logic                 land;
  logic [WIDTH-1:0]     land_data;
  logic [1:0]           occ_left;
  logic                 out_valid;

  function automatic logic [1:0] slot_next(input logic [1:0] p);
    return (p == SLOTS_CNT - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

  assign out_valid = (skid_cnt_q != 2'd0);

  // occ counts reads issued but not yet popped; it caps the prefetch at SLOTS words.
  always_comb begin
    wr_acc    = CFG_OK && we && !full_q;
    pop       = out_valid && dout_ready;
    occ_left  = occ_q - {1'b0, pop};
    issue     = (bram_cnt_q != '0) && (occ_left < SLOTS_CNT);
    land      = (LATENCY == 2) ? vld_q[1] : vld_q[0];
    land_data = (LATENCY == 2) ? bram_out_q : bram_rd_q;

    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = issue  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    vld_d    = {vld_q[0], issue};

    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case ({wr_acc, issue})
      2'b10:   bram_cnt_d = bram_cnt_q + CNT_ONE;
      2'b01:   bram_cnt_d = bram_cnt_q - CNT_ONE;
      default: bram_cnt_d = bram_cnt_q;
    endcase

    unique case ({issue, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    skid_d = skid_q;
    tail_d = tail_q;
    head_d = head_q;
    if (land) begin
      skid_d[tail_q] = land_data;
      tail_d         = slot_next(tail_q);
    end
    if (pop) begin
      head_d = slot_next(head_q);
    end

    unique case ({land, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase

    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bram_cnt_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      occ_q      <= '0;
      vld_q      <= '0;
      skid_q     <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      skid_cnt_q <= '0;
    end else if (ce) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bram_cnt_q <= bram_cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      occ_q      <= occ_d;
      vld_q      <= vld_d;
      skid_q     <= skid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Block RAM body: no reset so it maps onto the primitive; stale data is fenced by vld_q.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_acc && rst_n) begin
        mem[wr_ptr_q] <= din;
      end
      if (issue) begin
        bram_rd_q <= mem[rd_ptr_q];
      end
      bram_out_q <= bram_rd_q;
    end
  end

  assign dout       = skid_q[head_q];
  assign dout_valid = out_valid;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;

`ifdef BRAM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (we && full_q);
    underflow_d = underflow_q || (dout_ready && !out_valid && empty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (ce) begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo: stimulus pushes accepted words into a model queue,
// a negedge monitor pops and compares whenever the FIFO hands a word out.
module tb_bram_fifo;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 10;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ce;
  logic [WIDTH-1:0]     din;
  logic                 we;
  logic                 full;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 empty;
  logic [ADDR_BITS:0]   count;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  logic                 overflow;
  logic                 underflow;
`endif

  bram_fifo #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .TARGET_BRAM("36Kb"),
    .TARGET_DEVICE("VIRTEX5"), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .we(we), .full(full),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .empty(empty), .count(count)
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]   model_q [$];
  int                 vectors = 0;
  int                 miscompares = 0;
  bit                 checking = 0;
  int                 wr_this_cycle = 0;
  bit                 hold_pending = 0;
  bit                 prev_ce_low = 0;
  logic [WIDTH-1:0]   held_dout;
  logic [ADDR_BITS:0] prev_count;
  logic               prev_valid;

  function automatic void check_output(input string name, input longint actual,
                                       input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Drives one cycle of inputs; a word joins the model queue if the FIFO must accept it.
  task automatic apply_stimulus(input bit r_n, input bit c, input bit w,
                                input logic [WIDTH-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    rst_n         = r_n;
    ce            = c;
    we            = w;
    din           = d;
    dout_ready    = rdy;
    wr_this_cycle = 0;
    if (r_n && c && w && (model_q.size() < DEPTH)) begin
      model_q.push_back(d);
      wr_this_cycle = 1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      apply_stimulus(1, 1, 0, '0, 1);
      sample();
      if (model_q.size() == 0 && empty) done = 1;
    end
    check_output({tag, "_empty"}, longint'(empty), 1);
    check_output({tag, "_model_left"}, longint'(model_q.size()), 0);
  endtask

  // Monitor: checks occupancy against the model and pops expected words on each handoff.
  always @(negedge clk) begin
    int               exp_cnt;
    bit               do_pop;
    logic [WIDTH-1:0] exp_word;
    if (checking) begin
      exp_cnt = model_q.size() - wr_this_cycle;
      check_output("count", longint'(count), longint'(exp_cnt));
      check_output("empty", longint'(empty), longint'(exp_cnt == 0));
      check_output("full", longint'(full), longint'(exp_cnt == DEPTH));
      if (exp_cnt == 0) check_output("valid_when_empty", longint'(dout_valid), 0);
      if (hold_pending) begin
        check_output("hold_valid", longint'(dout_valid), 1);
        check_output("hold_data", longint'(dout), longint'(held_dout));
      end
      if (prev_ce_low) begin
        check_output("ce_freeze_count", longint'(count), longint'(prev_count));
        check_output("ce_freeze_valid", longint'(dout_valid), longint'(prev_valid));
      end
      do_pop = rst_n && ce && dout_valid && dout_ready;
      if (!rst_n) begin
        model_q.delete();
      end else if (do_pop && exp_cnt > 0) begin
        exp_word = model_q.pop_front();
        check_output("data", longint'(dout), longint'(exp_word));
      end
      hold_pending = rst_n && dout_valid && !do_pop;
      held_dout    = dout;
      prev_ce_low  = rst_n && !ce;
      prev_count   = count;
      prev_valid   = dout_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_BITS:0] steady;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; din = '0; dout_ready = 1'b0;
    steady = '0;

    // Reset must act even with ce low and ignore we/dout_ready.
    apply_stimulus(0, 0, 0, '0, 0);
    apply_stimulus(0, 1, 1, '1, 1);
    apply_stimulus(1, 0, 0, '0, 0);
    checking = 1;
    sample();
    check_output("reset_dout", longint'(dout), 0);
    check_output("reset_valid", longint'(dout_valid), 0);
    check_output("reset_empty", longint'(empty), 1);
    check_output("reset_full", longint'(full), 0);
    check_output("reset_count", longint'(count), 0);

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    apply_stimulus(1, 1, 0, '0, 1);
    apply_stimulus(1, 1, 0, '0, 0);
    sample();
    check_output("underflow_set", longint'(underflow), 1);
    check_output("overflow_clear", longint'(overflow), 0);
`endif

    // First-word latency: valid exactly LATENCY+1 enabled cycles after the write edge.
    apply_stimulus(1, 1, 1, 32'h11, 1);
    for (int k = 0; k <= LATENCY + 1; k++) begin
      apply_stimulus(1, 1, 0, '0, 1);
      sample();
      check_output("latency_valid", longint'(dout_valid), longint'(k == LATENCY + 1));
    end
    apply_stimulus(1, 1, 0, '0, 0);
    sample();
    check_output("after_pop_count", longint'(count), 0);
    check_output("after_pop_empty", longint'(empty), 1);

    // Fill to capacity, then try one more write that must be dropped.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 1, 1, WIDTH'(i), 0);
    apply_stimulus(1, 1, 1, WIDTH'(DEPTH), 0);
    apply_stimulus(1, 1, 0, '0, 0);
    sample();
    check_output("fill_full", longint'(full), 1);
    check_output("fill_count", longint'(count), DEPTH);
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    check_output("overflow_set", longint'(overflow), 1);
`endif

    // Write and pop together while full: pop wins, the write is lost.
    apply_stimulus(1, 1, 1, 32'hDEAD_BEEF, 1);
    apply_stimulus(1, 1, 0, '0, 0);
    sample();
    check_output("full_wr_pop_count", longint'(count), DEPTH - 1);
    check_output("full_wr_pop_full", longint'(full), 0);
    drain("fill");

    // Continuous streaming across pointer wrap with no bubbles once primed.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(1, 1, 1, WIDTH'($urandom), 1);
      sample();
      if (i == 20) steady = count;
      if (i > 20) begin
        check_output("stream_valid", longint'(dout_valid), 1);
        check_output("stream_count", longint'(count), longint'(steady));
      end
    end
    drain("stream");

    // Random traffic, 50% backpressure, ce low every third cycle.
    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(1, (i % 3) != 2, 1'($urandom_range(0, 1)), WIDTH'($urandom),
                     1'($urandom_range(0, 1)));
    end
    drain("random");

    // Reset with 500 words held and reads in flight.
    for (int i = 0; i < 500; i++) apply_stimulus(1, 1, 1, WIDTH'(32'h1000 + i), 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 1, 1, WIDTH'($urandom), 1);
    apply_stimulus(0, 1, 1, WIDTH'($urandom), 1);
    apply_stimulus(1, 1, 0, '0, 1);
    sample();
    check_output("midreset_count", longint'(count), 0);
    check_output("midreset_empty", longint'(empty), 1);
    check_output("midreset_valid", longint'(dout_valid), 0);
    for (int i = 0; i < 20; i++) apply_stimulus(1, 1, 0, '0, 1);
    for (int i = 0; i < 40; i++) apply_stimulus(1, 1, 1, WIDTH'($urandom), 1'($urandom_range(0, 1)));
    drain("post_reset");

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, valid range 1-72, and values above 36 require TARGET_BRAM="36Kb".
REQ-002 Parameter ADDR_BITS, default 10: log2 of capacity, so capacity DEPTH = 2^ADDR_BITS words, minimum 9.
REQ-003 Parameter TARGET_BRAM, default "36Kb": "18Kb" or "36Kb".
REQ-004 Parameter TARGET_DEVICE, default "VIRTEX5": "VIRTEX5", "VIRTEX6" or "SPARTAN6".
REQ-005 Parameter LATENCY, default 2: BRAM read latency, 1 or 2; the BRAM output register is enabled when LATENCY=2.
REQ-006 Port clk, input, 1 bit: the single clock; every register is on its rising edge.
REQ-007 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 Port ce, input, 1 bit: clock enable (Simulink); all state SHALL hold while ce=0.
REQ-009 Port din, input, WIDTH bits: write data.
REQ-010 Port we, input, 1 bit: write request.
REQ-011 Port full, output, 1 bit: high when count equals DEPTH.
REQ-012 Port dout, output, WIDTH bits: head-of-queue data, first-word-fall-through.
REQ-013 Port dout_valid, output, 1 bit: dout holds a valid word.
REQ-014 Port dout_ready, input, 1 bit: the consumer accepts dout.
REQ-015 Port empty, output, 1 bit: high when count equals 0.
REQ-016 Port count, output, ADDR_BITS+1 bits: number of words held, counting BRAM words, words in flight and the output stage.

Function
REQ-017 A write SHALL be accepted when ce=1, we=1 and full=0, storing din at the write pointer and then incrementing the pointer modulo DEPTH.
REQ-018 A write attempted while full=1 SHALL be dropped, leaving the memory, the pointers and count unchanged.
REQ-019 A pop SHALL occur when ce=1, dout_valid=1 and dout_ready=1.
REQ-020 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-021 A prefetch stage of LATENCY+1 entries SHALL issue BRAM reads whenever it has a free slot and the BRAM is non-empty, giving sustained throughput of 1 word per enabled cycle in both directions.
REQ-022 Latency: a word written at enabled cycle N into an empty FIFO with an idle output SHALL present with dout_valid=1 at cycle N+LATENCY+1.
REQ-023 Words SHALL leave in exact write order.
REQ-024 count SHALL increment on an accepted write, decrement on a pop, and stay unchanged when both occur in the same cycle.
REQ-025 full and empty SHALL be registered and derived from the next value of count.
REQ-026 A simultaneous write and pop while full=1 SHALL accept the pop and reject the write, because full is sampled at the start of the cycle.
REQ-027 A write while empty SHALL produce no pop in that cycle.
REQ-028 Both pointers SHALL wrap from DEPTH-1 to 0 without any gap.
REQ-029 A read and a write to the same BRAM address in one cycle SHALL never occur, because the prefetch only reads committed words.

Reset
REQ-030 When rst_n=0 at a clock edge, regardless of ce, the block SHALL set both pointers to 0, count to 0, empty to 1, full to 0, dout_valid to 0 and dout to 0, and clear all prefetch entries.
REQ-031 A reset mid-operation SHALL discard all stored and in-flight words, and BRAM data returning after the reset SHALL be ignored.
REQ-032 we and dout_ready SHALL be ignored during the reset cycle.

Configuration
REQ-033 When macro BRAM_FIFO_ERR_FLAGS_EN is defined, the block SHALL add output ports overflow (1 bit) and underflow (1 bit).
REQ-034 With BRAM_FIFO_ERR_FLAGS_EN defined, overflow SHALL become set and stay set after any write attempted while full.
REQ-035 With BRAM_FIFO_ERR_FLAGS_EN defined, underflow SHALL become set and stay set after any cycle with ce=1, dout_ready=1 and dout_valid=0 while empty=1.
REQ-036 With BRAM_FIFO_ERR_FLAGS_EN defined, overflow and underflow SHALL be cleared only by reset.
REQ-037 When BRAM_FIFO_ERR_FLAGS_EN is undefined, the overflow and underflow ports SHALL be absent and no related logic SHALL exist.

Verification
REQ-038 Reset, then write 0x11 at cycle 0 with dout_ready=1 and LATENCY=2 -> dout=0x11 and dout_valid=1 at cycle 3, count goes 1 then 0 after the pop, and empty=1 afterwards.
REQ-039 Write 1024 ascending words with dout_ready=0 and ADDR_BITS=10 -> full=1 and count=1024; a 1025th write is dropped (overflow=1 when the macro is defined); draining then yields 0..1023 in order.
REQ-040 Continuous write and read for 3000 cycles -> data in order across pointer wrap, count constant after fill, and no bubble on dout_valid once primed.
REQ-041 Random dout_ready backpressure at 50 %, plus ce toggling every third cycle -> dout stable while stalled, no loss or duplication, and nothing changes while ce=0.
REQ-042 Assert rst_n=0 for one cycle with 500 words held and reads in flight -> the next cycle shows count=0, empty=1 and dout_valid=0, and no stale word appears later.
REQ-043 Full FIFO with we=1 and a pop in the same cycle -> count becomes DEPTH-1 and the written word is not stored.
